data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and access sequencer in front of the single-cycle core's byte-addressed data memory (combinational read, write on posedge). Shares the one memory port between the CPU load/store path and the test-data loader port. Serialises requests round-robin, checks size/alignment, drives the memory control lines for exactly one access cycle, and returns registered read data with a one-cycle acknowledge.

## Interface
- WA, 32, address width
- WD, 32, data width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU request; held with payload until cpu_gnt
- cpu_addr  in  WA  byte address
- cpu_we  in  1  1 = store, 0 = load
- cpu_func3  in  3  RV32I size/sign code (000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu)
- cpu_wdata  in  WD  store data, right-aligned
- cpu_gnt  out  1  request accepted this cycle (combinational)
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  valid with cpu_ack; illegal func3 or misaligned
- cpu_rdata  out  WD  load result, valid with cpu_ack
- ldr_req, ldr_addr, ldr_we, ldr_func3, ldr_wdata, ldr_gnt, ldr_ack, ldr_err, ldr_rdata: loader port, identical semantics
- mem_addr  out  WA  address to data memory
- mem_we  out  1  memory write enable
- mem_func3  out  3  size code to data memory
- mem_wdata  out  WD  write data to data memory
- mem_rdata  in  WD  combinational read data from data memory

## Operation
- States: IDLE, BUSY. Reset: IDLE, last_owner = LDR (so CPU wins first tie), all gnt/ack/err = 0, rdata = 0, mem_addr/mem_wdata/mem_func3 = 0, mem_we = 0.
- IDLE, no req: stay. One req: grant it. Both: grant the port that is not last_owner.
- On grant: gnt high that cycle; latch addr, we, func3, wdata, owner; set last_owner; compute err; go BUSY.
- err = 1 when func3 is 011, 110 or 111; func3 is 1xx with we = 1; func3[1:0] = 01 with addr[0] = 1; func3[1:0] = 10 with addr[1:0] != 00.
- BUSY: mem_addr/mem_func3/mem_wdata driven from latch; mem_we = latched we AND NOT err. No grants issued. End of cycle: owner's ack <= 1, err <= latched err, rdata <= (read and not err) ? mem_rdata : 0 (unchanged on writes); go IDLE.
- Outside BUSY mem_we = 0; mem_addr/mem_func3/mem_wdata hold last latched values.
- Memory byte order is big-endian (byte at addr is MSB of lw); sign/zero extension is done by the memory; arbiter passes mem_rdata unmodified.

## Timing
- Request sampled in IDLE at cycle N: gnt in N, memory access in N+1 (write commits at end of N+1), ack/err/rdata visible in N+2 for one cycle; rdata holds until next read ack for that port.
- Throughput: one access per 2 cycles. A req still high in N+2 is arbitrated in N+2 (state is IDLE again).
- req asserted while BUSY: no gnt; evaluated on return to IDLE.
- Both ports continuously requesting: grants strictly alternate, max wait 2 access slots.
- Payload may change or req drop in the cycle after gnt; latched copy is used.
- rst asserted in BUSY: mem_we falls immediately (asynchronous), pending write does not commit, no ack issued, FSM to IDLE, last_owner = LDR.
- err access: no memory write, ack still issued on schedule.

## Test plan
- Reset: rst high mid-run -> all outputs 0, state IDLE within same cycle; first tie after release granted to CPU.
- CPU lw 0x10000, memory bytes 12 34 56 78 -> cpu_gnt at N, mem_we = 0 at N+1, cpu_ack and cpu_rdata = 0x12345678 at N+2, cpu_err = 0.
- Loader sw 0xDEADBEEF to 0x10004, then CPU lw 0x10004 -> ldr_ack at N+2, cpu_rdata = 0xDEADBEEF; mem_we high only in N+1.
- Both ports request continuously from reset -> gnt order CPU, LDR, CPU, LDR, grants 2 cycles apart, acks matching owner.
- CPU sh to 0x10001 and lw to 0x10002 -> cpu_err = 1 with ack at N+2, mem_we never high, memory unchanged, cpu_rdata = 0 for the lw.
- Loader sw in progress, rst pulsed during BUSY -> mem_we drops immediately, target word unchanged, no ldr_ack.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one combinational-read, byte-addressed data memory port
// between the CPU load/store path and the test-data loader. Requests are granted
// round-robin from IDLE. Each granted access occupies the memory for exactly one
// BUSY cycle and is acknowledged, with its error flag and read data, one cycle later.
module data_mem_arbiter #(
    parameter int WA = 32,
    parameter int WD = 32
) (
    input  logic          clk,
    input  logic          rst,
    // CPU load/store port
    input  logic          cpu_req,
    input  logic [WA-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [2:0]    cpu_func3,
    input  logic [WD-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_ack,
    output logic          cpu_err,
    output logic [WD-1:0] cpu_rdata,
    // test-data loader port
    input  logic          ldr_req,
    input  logic [WA-1:0] ldr_addr,
    input  logic          ldr_we,
    input  logic [2:0]    ldr_func3,
    input  logic [WD-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_ack,
    output logic          ldr_err,
    output logic [WD-1:0] ldr_rdata,
    // data memory
    output logic [WA-1:0] mem_addr,
    output logic          mem_we,
    output logic [2:0]    mem_func3,
    output logic [WD-1:0] mem_wdata,
    input  logic [WD-1:0] mem_rdata
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_LDR
    } owner_e;

    state_e        state_q, state_d;
    owner_e        last_owner_q, last_owner_d;
    owner_e        owner_q, owner_d;
    logic [WA-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [2:0]    func3_q, func3_d;
    logic [WD-1:0] wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          cpu_err_q, cpu_err_d;
    logic [WD-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          ldr_ack_q, ldr_ack_d;
    logic          ldr_err_q, ldr_err_d;
    logic [WD-1:0] ldr_rdata_q, ldr_rdata_d;

    logic idle;
    logic pick_cpu;
    logic pick_ldr;

    // Illegal size code, store with an unsigned-load code, or a misaligned half/word.
    function automatic logic access_err(input logic [1:0] addr_lo, input logic we,
                                        input logic [2:0] func3);
        logic bad;
        bad = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
        bad = bad || (func3[2] && we);
        bad = bad || ((func3[1:0] == 2'b01) && addr_lo[0]);
        bad = bad || ((func3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return bad;
    endfunction

    // Round-robin pick: a lone request wins, a tie goes to the port that did not own
    // the previous access. Gated by rst so no grant is shown while reset is held.
    assign idle     = (state_q == IDLE) && !rst;
    assign pick_cpu = idle && cpu_req && (!ldr_req || (last_owner_q == OWN_LDR));
    assign pick_ldr = idle && ldr_req && (!cpu_req || (last_owner_q == OWN_CPU));

    assign cpu_gnt   = pick_cpu;
    assign ldr_gnt   = pick_ldr;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_ack   = ldr_ack_q;
    assign ldr_err   = ldr_err_q;
    assign ldr_rdata = ldr_rdata_q;

    // Memory lines come straight from the latched request. The write enable is decoded
    // from the state flop so an asynchronous reset in BUSY removes it immediately.
    assign mem_addr  = addr_q;
    assign mem_func3 = func3_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = (state_q == BUSY) && we_q && !err_q;

    // Next-state logic: latch the winner in IDLE, complete the access in BUSY.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned
        // and no latch is inferred.
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        func3_d      = func3_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        cpu_ack_d    = 1'b0;
        cpu_err_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        ldr_ack_d    = 1'b0;
        ldr_err_d    = 1'b0;
        ldr_rdata_d  = ldr_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_cpu || pick_ldr) begin
                    state_d      = BUSY;
                    owner_d      = pick_cpu ? OWN_CPU : OWN_LDR;
                    last_owner_d = owner_d;
                    addr_d       = pick_cpu ? cpu_addr  : ldr_addr;
                    we_d         = pick_cpu ? cpu_we    : ldr_we;
                    func3_d      = pick_cpu ? cpu_func3 : ldr_func3;
                    wdata_d      = pick_cpu ? cpu_wdata : ldr_wdata;
                    err_d        = access_err(addr_d[1:0], we_d, func3_d);
                end
            end
            BUSY: begin
                state_d = IDLE;
                if (owner_q == OWN_CPU) begin
                    cpu_ack_d = 1'b1;
                    cpu_err_d = err_q;
                    if (!we_q) begin
                        cpu_rdata_d = err_q ? '0 : mem_rdata;
                    end
                end else begin
                    ldr_ack_d = 1'b1;
                    ldr_err_d = err_q;
                    if (!we_q) begin
                        ldr_rdata_d = err_q ? '0 : mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset leaves the CPU first in line for a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_LDR;
            owner_q      <= OWN_CPU;
            addr_q       <= '0;
            we_q         <= 1'b0;
            func3_q      <= 3'b000;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            ldr_ack_q    <= 1'b0;
            ldr_err_q    <= 1'b0;
            ldr_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            func3_q      <= func3_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_err_q    <= cpu_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_ack_q    <= ldr_ack_d;
            ldr_err_q    <= ldr_err_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: drives both ports with directed and random requests, emulates
// the big-endian data memory, and compares every output each cycle against a
// transaction-level reference (cycle bookkeeping plus a shadow byte array).
module tb_data_mem_arbiter;

    localparam int WA = 32;
    localparam int WD = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_ack, cpu_err;
    logic [WA-1:0] cpu_addr;
    logic [2:0]    cpu_func3;
    logic [WD-1:0] cpu_wdata, cpu_rdata;
    logic          ldr_req, ldr_we, ldr_gnt, ldr_ack, ldr_err;
    logic [WA-1:0] ldr_addr;
    logic [2:0]    ldr_func3;
    logic [WD-1:0] ldr_wdata, ldr_rdata;
    logic [WA-1:0] mem_addr;
    logic          mem_we;
    logic [2:0]    mem_func3;
    logic [WD-1:0] mem_wdata, mem_rdata;

    data_mem_arbiter #(.WA(WA), .WD(WD)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_func3(cpu_func3),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_we(ldr_we), .ldr_func3(ldr_func3),
        .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_ack(ldr_ack), .ldr_err(ldr_err),
        .ldr_rdata(ldr_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_func3(mem_func3),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- data memory: 256 bytes, big-endian, sign-extending reads
    logic [7:0] mem  [0:255];
    logic [7:0] smem [0:255];
    logic [7:0] wa0, wa1, wa2, wa3;
    logic [7:0] b0, b1, b2, b3;

    assign wa0 = mem_addr[7:0];
    assign wa1 = wa0 + 8'd1;
    assign wa2 = wa0 + 8'd2;
    assign wa3 = wa0 + 8'd3;

    always_comb begin
        b0 = mem[wa0];
        b1 = mem[wa1];
        b2 = mem[wa2];
        b3 = mem[wa3];
        case (mem_func3)
            3'b000:  mem_rdata = {{24{b0[7]}}, b0};
            3'b100:  mem_rdata = {24'd0, b0};
            3'b001:  mem_rdata = {{16{b0[7]}}, b0, b1};
            3'b101:  mem_rdata = {16'd0, b0, b1};
            default: mem_rdata = {b0, b1, b2, b3};
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_func3[1:0])
                2'b00: mem[wa0] <= mem_wdata[7:0];
                2'b01: begin
                    mem[wa0] <= mem_wdata[15:8];
                    mem[wa1] <= mem_wdata[7:0];
                end
                default: begin
                    mem[wa0] <= mem_wdata[31:24];
                    mem[wa1] <= mem_wdata[23:16];
                    mem[wa2] <= mem_wdata[15:8];
                    mem[wa3] <= mem_wdata[7:0];
                end
            endcase
        end
    end

    // ---------------- bookkeeping
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction level)
    int          free_cyc;            // first cycle the arbiter may grant again
    bit          last_ldr;            // previous owner was the loader
    bit          acc_pend, acc_own, acc_we, acc_err;
    int          acc_cyc;
    logic [31:0] acc_addr, acc_wd;
    logic [2:0]  acc_f3;
    bit          ack_pend, ack_own, ack_err, ack_upd;
    int          ack_cyc;
    logic [31:0] ack_rd;
    logic [31:0] m_rd_cpu, m_rd_ldr, m_addr, m_wd;
    logic [2:0]  m_f3;
    int          cpu_mode, ldr_mode;  // 0 one-shot, 1 hold request, 2 random

    function automatic bit ref_err(input logic [31:0] a, input bit we, input logic [2:0] f3);
        int size;
        size = 1 << f3[1:0];
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
        if (we && f3[2]) return 1'b1;
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        int          n;
        logic [31:0] v;
        n = 1 << f3[1:0];
        v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(smem[8'(a[7:0] + i)]);
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) smem[8'(a[7:0] + i)] = 8'(wd >> (8 * (n - 1 - i)));
    endtask

    task automatic model_reset();
        free_cyc = cyc;
        last_ldr = 1'b1;
        acc_pend = 1'b0;
        ack_pend = 1'b0;
        m_rd_cpu = '0;
        m_rd_ldr = '0;
        m_addr   = '0;
        m_wd     = '0;
        m_f3     = 3'b000;
    endtask

    task automatic rand_payload(output logic [31:0] addr, output logic we,
                                output logic [2:0] f3, output logic [31:0] wd);
        int         size;
        logic [7:0] off;
        if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
        else begin
            case ($urandom_range(0, 4))
                0:       f3 = 3'b000;
                1:       f3 = 3'b001;
                2:       f3 = 3'b010;
                3:       f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
        end
        we   = f3[2] ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
        size = 1 << f3[1:0];
        off  = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) off = off & ~8'(size - 1);
        addr = 32'h0001_0000 | 32'(off);
        wd   = $urandom;
    endtask

    // One clock cycle: check all outputs, advance the model, step the stimulus.
    task automatic tick();
        bit idle, eg_c, eg_l, in_acc, in_ack;
        #1;
        idle   = (cyc >= free_cyc);
        eg_c   = idle && cpu_req && (!ldr_req || last_ldr);
        eg_l   = idle && ldr_req && (!cpu_req || !last_ldr);
        in_acc = acc_pend && (cyc == acc_cyc);
        in_ack = ack_pend && (cyc == ack_cyc);
        if (in_ack) begin
            if (ack_upd) begin
                if (ack_own) m_rd_ldr = ack_rd;
                else         m_rd_cpu = ack_rd;
            end
            ack_pend = 1'b0;
        end

        check("cpu_gnt",   cpu_gnt,   eg_c);
        check("ldr_gnt",   ldr_gnt,   eg_l);
        check("cpu_ack",   cpu_ack,   in_ack && !ack_own);
        check("cpu_err",   cpu_err,   in_ack && !ack_own && ack_err);
        check("ldr_ack",   ldr_ack,   in_ack && ack_own);
        check("ldr_err",   ldr_err,   in_ack && ack_own && ack_err);
        check("cpu_rdata", cpu_rdata, m_rd_cpu);
        check("ldr_rdata", ldr_rdata, m_rd_ldr);
        check("mem_we",    mem_we,    in_acc && acc_we && !acc_err);
        check("mem_addr",  mem_addr,  m_addr);
        check("mem_func3", mem_func3, m_f3);
        check("mem_wdata", mem_wdata, m_wd);

        if (in_acc) begin
            ack_pend = 1'b1;
            ack_cyc  = cyc + 1;
            ack_own  = acc_own;
            ack_err  = acc_err;
            ack_upd  = !acc_we;
            ack_rd   = acc_err ? 32'd0 : ref_load(acc_addr, acc_f3);
            if (acc_we && !acc_err) ref_store(acc_addr, acc_f3, acc_wd);
            acc_pend = 1'b0;
        end
        if (eg_c || eg_l) begin
            acc_pend = 1'b1;
            acc_cyc  = cyc + 1;
            acc_own  = eg_l;
            acc_addr = eg_l ? ldr_addr  : cpu_addr;
            acc_we   = eg_l ? ldr_we    : cpu_we;
            acc_f3   = eg_l ? ldr_func3 : cpu_func3;
            acc_wd   = eg_l ? ldr_wdata : cpu_wdata;
            acc_err  = ref_err(acc_addr, acc_we, acc_f3);
            last_ldr = eg_l;
            free_cyc = cyc + 2;
            m_addr   = acc_addr;
            m_f3     = acc_f3;
            m_wd     = acc_wd;
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;

        if (eg_c) begin
            if (cpu_mode == 0) cpu_req = 1'b0;
            else if (cpu_mode == 2) begin
                cpu_req = ($urandom_range(0, 3) != 0);
                rand_payload(cpu_addr, cpu_we, cpu_func3, cpu_wdata);
            end
        end else if (cpu_mode == 2 && !cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_req = 1'b1;
            rand_payload(cpu_addr, cpu_we, cpu_func3, cpu_wdata);
        end
        if (eg_l) begin
            if (ldr_mode == 0) ldr_req = 1'b0;
            else if (ldr_mode == 2) begin
                ldr_req = ($urandom_range(0, 3) != 0);
                rand_payload(ldr_addr, ldr_we, ldr_func3, ldr_wdata);
            end
        end else if (ldr_mode == 2 && !ldr_req && $urandom_range(0, 2) == 0) begin
            ldr_req = 1'b1;
            rand_payload(ldr_addr, ldr_we, ldr_func3, ldr_wdata);
        end
    endtask

    // One-shot access on one port, run through grant, access and acknowledge.
    task automatic run_op(input bit ldr, input logic [31:0] a, input logic we,
                          input logic [2:0] f3, input logic [31:0] wd);
        if (ldr) begin
            ldr_req = 1'b1; ldr_addr = a; ldr_we = we; ldr_func3 = f3; ldr_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_func3 = f3; cpu_wdata = wd;
        end
        repeat (3) tick();
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_func3 = 3'b000; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_addr = '0; ldr_we = 1'b0; ldr_func3 = 3'b000; ldr_wdata = '0;
        cpu_mode = 0;
        ldr_mode = 0;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            mem[i] <= b;
            smem[i] = b;
        end
        mem[0] <= 8'h12; mem[1] <= 8'h34; mem[2] <= 8'h56; mem[3] <= 8'h78;
        smem[0] = 8'h12; smem[1] = 8'h34; smem[2] = 8'h56; smem[3] = 8'h78;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state, then a plain CPU word load of 12 34 56 78
        tick();
        run_op(1'b0, 32'h0001_0000, 1'b0, 3'b010, 32'd0);
        check("lw_10000", cpu_rdata, 32'h1234_5678);

        // loader store, CPU reads it back
        run_op(1'b1, 32'h0001_0004, 1'b1, 3'b010, 32'hDEAD_BEEF);
        run_op(1'b0, 32'h0001_0004, 1'b0, 3'b010, 32'd0);
        check("lw_10004", cpu_rdata, 32'hDEAD_BEEF);

        // misaligned half store and word load: error, no write, zero read data
        run_op(1'b0, 32'h0001_0001, 1'b1, 3'b001, 32'h0000_AAAA);
        run_op(1'b0, 32'h0001_0002, 1'b0, 3'b010, 32'd0);
        check("lw_misaligned", cpu_rdata, 32'd0);

        // reset while a loader store is in its memory cycle
        ldr_req = 1'b1; ldr_addr = 32'h0001_0008; ldr_we = 1'b1;
        ldr_func3 = 3'b010; ldr_wdata = 32'hCAFE_F00D;
        tick();
        cpu_req = 1'b1; cpu_addr = 32'h0001_0000; cpu_we = 1'b0;
        cpu_func3 = 3'b010; cpu_wdata = '0;
        #1;
        check("we_before_rst", mem_we, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mem_we",    mem_we,    1'b0);
        check("rst_mem_addr",  mem_addr,  32'd0);
        check("rst_cpu_gnt",   cpu_gnt,   1'b0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_no_ack", ldr_ack, 1'b0);
        @(negedge clk);
        cyc++;
        model_reset();
        rst = 1'b0;
        check("rst_word", {mem[8], mem[9], mem[10], mem[11]},
              {smem[8], smem[9], smem[10], smem[11]});

        // both ports requesting loads continuously: CPU first, then strict alternation
        ldr_req = 1'b1; ldr_addr = 32'h0001_0004; ldr_we = 1'b0;
        ldr_func3 = 3'b010; ldr_wdata = '0;
        cpu_mode = 1;
        ldr_mode = 1;
        repeat (10) tick();

        // random traffic on both ports
        cpu_mode = 2;
        ldr_mode = 2;
        repeat (3000) tick();

        // drain and compare the whole memory against the shadow copy
        cpu_mode = 0;
        ldr_mode = 0;
        cpu_req  = 1'b0;
        ldr_req  = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 256; i++) check("mem_byte", mem[i], smem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
